fifo_rd_stream_bridge: RTL

//  Read-side consumer for the asyfifo read port, in the rclk domain. Pulls words with fifo_re/fifo_empty,

---
 rtl/fifo_rd_pkg.sv | 27 ++
 rtl/stream_skid_buf.sv | 64 ++++++
 rtl/fifo_rd_stream_bridge.sv | 108 ++++++++++
 3 files changed

// File: rtl/fifo_rd_pkg.sv
// Shared types and width helpers for the FIFO read-side stream bridge.
// Widths are derived from the instantiating module's parameters via the helper functions.
package fifo_rd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } rd_state_t;

    localparam int DEF_DATA_W    = 8;
    localparam int DEF_BUF_DEPTH = 2;
    localparam int DEF_BURST_LEN = 4;

    function automatic int occ_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int bcnt_w(input int burst_len);
        return $clog2(burst_len);
    endfunction

endpackage

// File: rtl/stream_skid_buf.sv
// Small circular buffer that absorbs the FIFO read latency; exposes occupancy and the head word.
// Storage is not reset; only pointers and occupancy are.
module stream_skid_buf
    import fifo_rd_pkg::*;
#(
    parameter  int DATA_W    = DEF_DATA_W,
    parameter  int BUF_DEPTH = DEF_BUF_DEPTH,
    localparam int OCC_W     = occ_w(BUF_DEPTH),
    localparam int PTR_W     = ptr_w(BUF_DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [OCC_W-1:0]  occ,
    output logic [DATA_W-1:0] head_data,
    output logic              empty
);

    logic [DATA_W-1:0] mem [BUF_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              full;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    assign head_data = mem[rd_ptr];
    assign full      = (occ == OCC_W'(BUF_DEPTH));
    assign empty     = (occ == '0);

    // The credit rule upstream must make these impossible.
    a_no_push_full: assert property (@(posedge clk) disable iff (reset) !(push && full));
    a_no_pop_empty: assert property (@(posedge clk) disable iff (reset) !(pop && empty));

endmodule

// File: rtl/fifo_rd_stream_bridge.sv
// FIFO read-port consumer: credit-based fetch, latency skid buffer and burst-framed valid/ready stream.
// m_ready reaches fifo_re combinationally so a slot freed this cycle can be refilled immediately.
module fifo_rd_stream_bridge
    import fifo_rd_pkg::*;
#(
    parameter  int DATA_W    = DEF_DATA_W,
    parameter  int BUF_DEPTH = DEF_BUF_DEPTH,
    parameter  int BURST_LEN = DEF_BURST_LEN,
    localparam int OCC_W     = occ_w(BUF_DEPTH),
    localparam int BCNT_W    = bcnt_w(BURST_LEN)
) (
    input  logic              rclk,
    input  logic              rreset,
    input  logic              enable,
    input  logic              fifo_empty,
    output logic              fifo_re,
    input  logic [DATA_W-1:0] fifo_dout,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic [BCNT_W-1:0] beat_cnt,
    output logic              busy
);

    rd_state_t         state;
    rd_state_t         state_nxt;
    logic              rd_pend_p1;
    logic [OCC_W-1:0]  occ;
    logic              buf_empty;
    logic              pop;
    logic [OCC_W:0]    credit;

    stream_skid_buf #(
        .DATA_W    (DATA_W),
        .BUF_DEPTH (BUF_DEPTH)
    ) u_skid (
        .clk       (rclk),
        .reset     (rreset),
        .push      (rd_pend_p1),
        .push_data (fifo_dout),
        .pop       (pop),
        .occ       (occ),
        .head_data (m_data),
        .empty     (buf_empty)
    );

    assign m_valid = ~buf_empty;
    assign pop     = m_valid & m_ready;

    // Entries that will be held after this edge, counting the word still in flight.
    assign credit  = {1'b0, occ} + {{OCC_W{1'b0}}, rd_pend_p1} - {{OCC_W{1'b0}}, pop};
    assign fifo_re = enable & ~fifo_empty & ~rreset & (credit < (OCC_W + 1)'(BUF_DEPTH));

    // p0 -> p1: read request becomes a pending capture of fifo_dout
    always_ff @(posedge rclk) begin
        if (rreset) begin
            rd_pend_p1 <= 1'b0;
        end else begin
            rd_pend_p1 <= fifo_re;
        end
    end

    always_ff @(posedge rclk) begin
        if (rreset) begin
            beat_cnt <= '0;
        end else if (pop) begin
            beat_cnt <= (beat_cnt == BCNT_W'(BURST_LEN - 1)) ? '0 : beat_cnt + 1'b1;
        end
    end

    assign m_last = m_valid & (beat_cnt == BCNT_W'(BURST_LEN - 1));

    always_ff @(posedge rclk) begin
        if (rreset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (enable) state_nxt = RUN;
            end
            RUN: begin
                if (!enable) begin
                    state_nxt = (!buf_empty || rd_pend_p1 || fifo_re) ? DRAIN : IDLE;
                end
            end
            DRAIN: begin
                if (enable) begin
                    state_nxt = RUN;
                end else if (credit == '0 && !fifo_re) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

endmodule
